// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the Memory data-port-B arbiter.
// Data width follows `DATA_WIDTH when the build provides it, else 32.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package mem_arb_pkg;

  localparam int DW       = `DATA_WIDTH;
  localparam int AW       = 32;
  localparam int LAT_W    = 2;   // holds READ_LATENCY-1 for latencies 1..4
  localparam int STARVE_W = 8;   // holds STARVE_LIMIT up to 255

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RD_WAIT = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_LDR  = 2'd2
  } owner_t;

endpackage

// File: rtl/mem_port_arbiter_rr_picker.sv
// Two-way round-robin picker (CPU vs loader) with loader burst lock and a
// starvation counter that forces a CPU grant after STARVE_LIMIT locked loader grants.
module rr_picker
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 8
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   cpu_req_i,
  input  logic   ldr_req_i,
  input  logic   ldr_lock_i,
  input  logic   pick_i,
  output owner_t grant_o,
  output owner_t last_owner_o
);

  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

  owner_t              last_q, last_d;
  logic [STARVE_W-1:0] starve_q, starve_d;

  always_comb begin
    grant_o = OWN_NONE;
    if (cpu_req_i && ldr_req_i) grant_o = (last_q == OWN_CPU) ? OWN_LDR : OWN_CPU;
    else if (cpu_req_i)         grant_o = OWN_CPU;
    else if (ldr_req_i)         grant_o = OWN_LDR;
    // A locked loader burst keeps the port until the CPU has waited long enough.
    if (last_q == OWN_LDR && ldr_lock_i && ldr_req_i)
      grant_o = (cpu_req_i && starve_q == LIMIT) ? OWN_CPU : OWN_LDR;
  end

  always_comb begin
    last_d   = last_q;
    starve_d = starve_q;
    if (pick_i && grant_o != OWN_NONE) last_d = grant_o;
    if (!ldr_lock_i)
      starve_d = '0;
    else if (pick_i && grant_o == OWN_CPU)
      starve_d = '0;
    else if (pick_i && grant_o == OWN_LDR && cpu_req_i && starve_q != '1)
      starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q   <= OWN_CPU;
      starve_q <= '0;
    end else begin
      last_q   <= last_d;
      starve_q <= starve_d;
    end
  end

  assign last_owner_o = last_d;

endmodule

// File: rtl/mem_port_arbiter.sv
// Serializes CPU and UART-loader transactions onto Memory data port B.
// Optional MMIO_WRITE_GUARD_EN: suppresses loader writes to MMIO and flags them on LdrErr.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int READ_LATENCY = 1,
  parameter int STARVE_LIMIT = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          CpuReq,
  input  logic          CpuWe,
  input  logic [AW-1:0] CpuAddr,
  input  logic [DW-1:0] CpuWData,
  output logic          CpuAck,
  output logic [DW-1:0] CpuRData,
  input  logic          LdrReq,
  input  logic          LdrWe,
  input  logic [AW-1:0] LdrAddr,
  input  logic [DW-1:0] LdrWData,
  output logic          LdrAck,
  output logic [DW-1:0] LdrRData,
  input  logic          LdrLock,
  output logic          LdrErr,
  output logic [AW-1:0] AddressB,
  output logic [DW-1:0] WriteData,
  output logic          EnableWriteB,
  input  logic [DW-1:0] ReadDataB,
  input  logic          IsMMIO,
  output logic          Busy,
  output logic [1:0]    GrantOwner
);

  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(READ_LATENCY - 1);

  state_t          state_q;
  owner_t          owner_q;
  logic            we_q;
  logic [LAT_W-1:0] cnt_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q, cpu_rdata_q, ldr_rdata_q;
  logic            wr_stb_q, cpu_ack_q, ldr_ack_q, busy_q;

  owner_t          grant;
  owner_t          unused_last_owner;
  logic            sel_we;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;

  rr_picker #(.STARVE_LIMIT(STARVE_LIMIT)) u_picker (
    .clk          (clk),
    .reset        (reset),
    .cpu_req_i    (CpuReq),
    .ldr_req_i    (LdrReq),
    .ldr_lock_i   (LdrLock),
    .pick_i       (state_q == IDLE),
    .grant_o      (grant),
    .last_owner_o (unused_last_owner)
  );

  assign sel_we    = (grant == OWN_CPU) ? CpuWe    : LdrWe;
  assign sel_addr  = (grant == OWN_CPU) ? CpuAddr  : LdrAddr;
  assign sel_wdata = (grant == OWN_CPU) ? CpuWData : LdrWData;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      owner_q     <= OWN_NONE;
      we_q        <= 1'b0;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      ldr_rdata_q <= '0;
      wr_stb_q    <= 1'b0;
      cpu_ack_q   <= 1'b0;
      ldr_ack_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      wr_stb_q  <= 1'b0;
      cpu_ack_q <= 1'b0;
      ldr_ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant != OWN_NONE) begin
            state_q <= ACCESS;
            owner_q <= grant;
            busy_q  <= 1'b1;
            addr_q  <= sel_addr;
            we_q    <= sel_we;
            // Outputs are registered, so the write strobe and ack land in the ACCESS cycle.
            if (sel_we) begin
              wdata_q   <= sel_wdata;
              wr_stb_q  <= 1'b1;
              cpu_ack_q <= (grant == OWN_CPU);
              ldr_ack_q <= (grant == OWN_LDR);
            end
          end
        end
        ACCESS: begin
          if (we_q) begin
            state_q <= IDLE;
            owner_q <= OWN_NONE;
            busy_q  <= 1'b0;
          end else begin
            state_q   <= RD_WAIT;
            cnt_q     <= LAT_LOAD;
            cpu_ack_q <= (LAT_LOAD == '0) && (owner_q == OWN_CPU);
            ldr_ack_q <= (LAT_LOAD == '0) && (owner_q == OWN_LDR);
          end
        end
        RD_WAIT: begin
          if (cnt_q == '0) begin
            state_q <= IDLE;
            owner_q <= OWN_NONE;
            busy_q  <= 1'b0;
            if (owner_q == OWN_CPU) cpu_rdata_q <= ReadDataB;
            else                    ldr_rdata_q <= ReadDataB;
          end else begin
            cnt_q     <= cnt_q - 1'b1;
            cpu_ack_q <= (cnt_q == LAT_W'(1)) && (owner_q == OWN_CPU);
            ldr_ack_q <= (cnt_q == LAT_W'(1)) && (owner_q == OWN_LDR);
          end
        end
        default: begin
          state_q <= IDLE;
          owner_q <= OWN_NONE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign AddressB   = addr_q;
  assign WriteData  = wdata_q;
  assign Busy       = busy_q;
  assign GrantOwner = owner_q;
  assign CpuAck     = cpu_ack_q;
  assign LdrAck     = ldr_ack_q;
  // During the read ack cycle the memory data is passed straight through;
  // the registered copy holds it until the next read by that requester.
  assign CpuRData   = (cpu_ack_q && !we_q) ? ReadDataB : cpu_rdata_q;
  assign LdrRData   = (ldr_ack_q && !we_q) ? ReadDataB : ldr_rdata_q;

`ifdef MMIO_WRITE_GUARD_EN
  logic wr_block;
  assign wr_block     = wr_stb_q && (owner_q == OWN_LDR) && IsMMIO;
  assign EnableWriteB = wr_stb_q && !wr_block;
  assign LdrErr       = wr_block;
`else
  logic unused_mmio;
  assign unused_mmio  = IsMMIO;
  assign EnableWriteB = wr_stb_q;
  assign LdrErr       = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a READ_LATENCY=1 instance for most scenarios
// and a READ_LATENCY=3 instance for latency and mid-read reset.
module tb_mem_port_arbiter;

`ifdef MMIO_WRITE_GUARD_EN
  localparam logic GUARD = 1'b1;
`else
  localparam logic GUARD = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, ldr_req, ldr_we, ldr_lock, cpu_req3;
  logic [31:0] cpu_addr, cpu_wdata, ldr_addr, ldr_wdata;
  logic        cpu_ack, ldr_ack, ldr_err, we_b, busy, is_mmio;
  logic [31:0] cpu_rdata, ldr_rdata, addr_b, wdata_b, rdata_b;
  logic [1:0]  grant;
  logic        cpu_ack3, ldr_ack3, ldr_err3, we_b3, busy3;
  logic [31:0] cpu_rdata3, ldr_rdata3, addr_b3, wdata_b3, rdata_b3;
  logic [1:0]  grant3;

  // Clock / reset
  always #5 clk = ~clk;

  mem_port_arbiter #(.READ_LATENCY(1), .STARVE_LIMIT(8)) dut (
    .clk(clk), .reset(reset),
    .CpuReq(cpu_req), .CpuWe(cpu_we), .CpuAddr(cpu_addr), .CpuWData(cpu_wdata),
    .CpuAck(cpu_ack), .CpuRData(cpu_rdata),
    .LdrReq(ldr_req), .LdrWe(ldr_we), .LdrAddr(ldr_addr), .LdrWData(ldr_wdata),
    .LdrAck(ldr_ack), .LdrRData(ldr_rdata), .LdrLock(ldr_lock), .LdrErr(ldr_err),
    .AddressB(addr_b), .WriteData(wdata_b), .EnableWriteB(we_b), .ReadDataB(rdata_b),
    .IsMMIO(is_mmio), .Busy(busy), .GrantOwner(grant)
  );

  mem_port_arbiter #(.READ_LATENCY(3), .STARVE_LIMIT(8)) dut3 (
    .clk(clk), .reset(reset),
    .CpuReq(cpu_req3), .CpuWe(cpu_we), .CpuAddr(cpu_addr), .CpuWData(cpu_wdata),
    .CpuAck(cpu_ack3), .CpuRData(cpu_rdata3),
    .LdrReq(1'b0), .LdrWe(1'b0), .LdrAddr(32'h0), .LdrWData(32'h0),
    .LdrAck(ldr_ack3), .LdrRData(ldr_rdata3), .LdrLock(1'b0), .LdrErr(ldr_err3),
    .AddressB(addr_b3), .WriteData(wdata_b3), .EnableWriteB(we_b3), .ReadDataB(rdata_b3),
    .IsMMIO(1'b0), .Busy(busy3), .GrantOwner(grant3)
  );

  // Memory model: shared word array, 1-cycle read pipe for dut, 3-cycle for dut3
  logic [31:0] mem [16];
  logic [31:0] rd1, s1, s2, s3;
  always @(posedge clk) begin
    if (we_b) mem[addr_b[5:2]] <= wdata_b;
    rd1 <= mem[addr_b[5:2]];
    s1  <= mem[addr_b3[5:2]];
    s2  <= s1;
    s3  <= s2;
  end
  assign rdata_b  = rd1;
  assign rdata_b3 = s3;
  assign is_mmio  = (addr_b[31:16] == 16'hFFFF);

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  task automatic do_reset;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; cpu_req3 = 0;
    ldr_req = 0; ldr_we = 0; ldr_addr = 0; ldr_wdata = 0; ldr_lock = 0;
    repeat (2) @(negedge clk);
    checks++; if ({cpu_ack, ldr_ack, ldr_err, we_b, busy} !== 5'b0) begin errors++; $display("FAIL reset_flags: got %b expected 00000", {cpu_ack, ldr_ack, ldr_err, we_b, busy}); end
    checks++; if (grant !== 2'd0) begin errors++; $display("FAIL reset_grant: got %0d expected 0", grant); end
    checks++; if ({addr_b, wdata_b, cpu_rdata, ldr_rdata} !== 128'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", {addr_b, wdata_b, cpu_rdata, ldr_rdata}); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy: got %b expected 0", busy); end
  endtask

  task automatic test_cpu_write;
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h4; cpu_wdata = 32'h1234_5678;
    @(negedge clk);
    checks++; if (we_b !== 1'b1) begin errors++; $display("FAIL wr_strobe: got %b expected 1", we_b); end
    checks++; if (addr_b !== 32'h4) begin errors++; $display("FAIL wr_addr: got %h expected 00000004", addr_b); end
    checks++; if (wdata_b !== 32'h1234_5678) begin errors++; $display("FAIL wr_data: got %h expected 12345678", wdata_b); end
    checks++; if (cpu_ack !== 1'b1 || grant !== 2'd1 || busy !== 1'b1) begin errors++; $display("FAIL wr_ack_grant: got ack=%b grant=%0d busy=%b expected 1 1 1", cpu_ack, grant, busy); end
    cpu_req = 0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
    @(negedge clk);
    checks++; if (we_b !== 1'b0 || cpu_ack !== 1'b0 || busy !== 1'b0 || grant !== 2'd0) begin errors++; $display("FAIL wr_end: got we=%b ack=%b busy=%b grant=%0d expected 0 0 0 0", we_b, cpu_ack, busy, grant); end
    checks++; if (addr_b !== 32'h4 || wdata_b !== 32'h1234_5678) begin errors++; $display("FAIL wr_hold: got %h %h expected 00000004 12345678", addr_b, wdata_b); end
  endtask

  task automatic test_cpu_read;
    cpu_we = 0; cpu_addr = 32'h4; cpu_req = 1; cpu_req3 = 1;
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(negedge clk);
      if (cyc <= 2) begin
        checks++; if (cpu_ack !== (cyc == 2)) begin errors++; $display("FAIL rd1_ack_c%0d: got %b expected %b", cyc, cpu_ack, cyc == 2); end
      end
      checks++; if (cpu_ack3 !== (cyc == 4)) begin errors++; $display("FAIL rd3_ack_c%0d: got %b expected %b", cyc, cpu_ack3, cyc == 4); end
      if (cyc == 2) begin
        checks++; if (cpu_rdata !== 32'h1234_5678) begin errors++; $display("FAIL rd1_data: got %h expected 12345678", cpu_rdata); end
        cpu_req = 0;
      end
      if (cyc == 3) begin
        checks++; if (cpu_rdata !== 32'h1234_5678 || busy !== 1'b0) begin errors++; $display("FAIL rd1_hold: got data=%h busy=%b expected 12345678 0", cpu_rdata, busy); end
      end
      if (cyc == 4) begin
        checks++; if (cpu_rdata3 !== 32'h1234_5678) begin errors++; $display("FAIL rd3_data: got %h expected 12345678", cpu_rdata3); end
        cpu_req3 = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_simultaneous;
    do_reset();
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h8; cpu_wdata = 32'hAAAA_0001;
    ldr_req = 1; ldr_we = 1; ldr_addr = 32'hC; ldr_wdata = 32'hBBBB_0002; ldr_lock = 0;
    @(negedge clk);
    checks++; if (grant !== 2'd2 || ldr_ack !== 1'b1 || cpu_ack !== 1'b0) begin errors++; $display("FAIL sim_first: got grant=%0d lack=%b cack=%b expected 2 1 0", grant, ldr_ack, cpu_ack); end
    checks++; if (addr_b !== 32'hC || wdata_b !== 32'hBBBB_0002) begin errors++; $display("FAIL sim_first_bus: got %h %h expected 0000000c bbbb0002", addr_b, wdata_b); end
    ldr_req = 0;
    @(negedge clk);
    checks++; if (grant !== 2'd0 || ldr_ack !== 1'b0 || cpu_ack !== 1'b0) begin errors++; $display("FAIL sim_bubble: got grant=%0d lack=%b cack=%b expected 0 0 0", grant, ldr_ack, cpu_ack); end
    @(negedge clk);
    checks++; if (grant !== 2'd1 || cpu_ack !== 1'b1 || ldr_ack !== 1'b0 || addr_b !== 32'h8) begin errors++; $display("FAIL sim_second: got grant=%0d cack=%b lack=%b addr=%h expected 1 1 0 00000008", grant, cpu_ack, ldr_ack, addr_b); end
    cpu_req = 0;
    @(negedge clk);
    checks++; if (cpu_ack !== 1'b0 || ldr_ack !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL sim_end: got cack=%b lack=%b busy=%b expected 0 0 0", cpu_ack, ldr_ack, busy); end
  endtask

  task automatic test_lock_starve;
    logic [1:0] exp_g;
    do_reset();
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h10; cpu_wdata = 32'h0C0C_0C0C;
    ldr_req = 1; ldr_we = 1; ldr_addr = 32'h14; ldr_wdata = 32'h1D1D_1D1D; ldr_lock = 1;
    for (int n = 0; n < 10; n++) begin
      exp_g = (n == 8) ? 2'd1 : 2'd2;
      @(negedge clk);
      checks++; if (grant !== exp_g) begin errors++; $display("FAIL lock_grant_%0d: got %0d expected %0d", n, grant, exp_g); end
      checks++; if ({cpu_ack, ldr_ack} !== ((exp_g == 2'd1) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL lock_ack_%0d: got cack=%b lack=%b expected owner %0d", n, cpu_ack, ldr_ack, exp_g); end
      if (n == 9) begin
        cpu_req = 0; ldr_req = 0; ldr_lock = 0;
      end
      @(negedge clk);
    end
    checks++; if (busy !== 1'b0 || grant !== 2'd0) begin errors++; $display("FAIL lock_end: got busy=%b grant=%0d expected 0 0", busy, grant); end
  endtask

  task automatic test_reset_mid_read;
    cpu_we = 0; cpu_addr = 32'h4; cpu_req3 = 1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (busy3 !== 1'b1 || cpu_ack3 !== 1'b0) begin errors++; $display("FAIL mid_pre: got busy=%b ack=%b expected 1 0", busy3, cpu_ack3); end
    reset = 1'b0;
    #1;
    checks++; if ({busy3, cpu_ack3, we_b3, grant3} !== 5'b0) begin errors++; $display("FAIL mid_async_flags: got %b expected 00000", {busy3, cpu_ack3, we_b3, grant3}); end
    checks++; if (addr_b3 !== 32'h0 || cpu_rdata3 !== 32'h0) begin errors++; $display("FAIL mid_async_data: got %h %h expected 0 0", addr_b3, cpu_rdata3); end
    cpu_req3 = 0;
    repeat (2) @(negedge clk);
    checks++; if (cpu_ack3 !== 1'b0 || we_b !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_held: got ack3=%b we=%b busy=%b expected 0 0 0", cpu_ack3, we_b, busy); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (busy3 !== 1'b0 || cpu_ack3 !== 1'b0) begin errors++; $display("FAIL mid_release: got busy=%b ack=%b expected 0 0", busy3, cpu_ack3); end
    cpu_req3 = 1;
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(negedge clk);
      checks++; if (cpu_ack3 !== (cyc == 4)) begin errors++; $display("FAIL mid_fresh_ack_c%0d: got %b expected %b", cyc, cpu_ack3, cyc == 4); end
    end
    checks++; if (cpu_rdata3 !== 32'h1234_5678) begin errors++; $display("FAIL mid_fresh_data: got %h expected 12345678", cpu_rdata3); end
    cpu_req3 = 0;
    @(negedge clk);
  endtask

  task automatic test_mmio_guard;
    ldr_req = 1; ldr_we = 1; ldr_addr = 32'hFFFF_FF00; ldr_wdata = 32'hDEAD_BEEF; ldr_lock = 0;
    @(negedge clk);
    checks++; if (ldr_ack !== 1'b1 || grant !== 2'd2 || addr_b !== 32'hFFFF_FF00) begin errors++; $display("FAIL mmio_ldr_ack: got ack=%b grant=%0d addr=%h expected 1 2 ffffff00", ldr_ack, grant, addr_b); end
    checks++; if (we_b !== !GUARD) begin errors++; $display("FAIL mmio_ldr_we: got %b expected %b", we_b, !GUARD); end
    checks++; if (ldr_err !== GUARD) begin errors++; $display("FAIL mmio_ldr_err: got %b expected %b", ldr_err, GUARD); end
    ldr_req = 0;
    @(negedge clk);
    checks++; if ({ldr_ack, ldr_err, we_b} !== 3'b0) begin errors++; $display("FAIL mmio_ldr_end: got %b expected 000", {ldr_ack, ldr_err, we_b}); end
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'hFFFF_FF04; cpu_wdata = 32'h0000_CAFE;
    @(negedge clk);
    checks++; if ({cpu_ack, we_b, ldr_err, ldr_ack} !== 4'b1100) begin errors++; $display("FAIL mmio_cpu: got cack/we/err/lack=%b expected 1100", {cpu_ack, we_b, ldr_err, ldr_ack}); end
    cpu_req = 0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_cpu_write();
    test_cpu_read();
    test_simultaneous();
    test_lock_starve();
    test_reset_mid_read();
    test_mmio_guard();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Arbitrates data port B of the unified Memory between two requesters: the CPU load/store unit and the UART program loader. Each transaction is serialized onto AddressB/WriteData/EnableWriteB and the read result is returned with a one-cycle Ack pulse. Sits between the core/loader and Memory. Port A (instruction fetch) is untouched.

Parameters:
READ_LATENCY, 1, cycles from AddressB stable to ReadDataB valid (1..4)
STARVE_LIMIT, 8, max consecutive loader grants under LdrLock while CpuReq is pending (1..255)

Ports:
clk  in  1  single system clock, rising edge
reset  in  1  asynchronous, active-low; 0 = in reset
CpuReq  in  1  CPU request, level, held until CpuAck
CpuWe  in  1  1 = write, 0 = read
CpuAddr  in  32  byte address
CpuWData  in  32  write data
CpuAck  out  1  one-cycle completion pulse
CpuRData  out  32  read data, valid when CpuAck=1, held until the next CPU read
LdrReq, LdrWe, LdrAddr, LdrWData, LdrAck, LdrRData  same as the Cpu* ports, for the loader
LdrLock  in  1  loader burst lock
LdrErr  out  1  pulses with LdrAck when a write is rejected (optional feature only)
AddressB  out  32  to Memory
WriteData  out  32  to Memory
EnableWriteB  out  1  to Memory, single-cycle write strobe
ReadDataB  in  32  from Memory
IsMMIO  in  1  from Memory, decode of AddressB
Busy  out  1  state != IDLE
GrantOwner  out  2  0 none, 1 CPU, 2 loader

Behaviour:
- Reset (reset=0, async): state IDLE; all outputs 0; LastOwner=CPU; StarveCnt=0. Any in-flight transaction is dropped and no write is issued.
- FSM states: IDLE, ACCESS, RD_WAIT.
- IDLE: if any Req is high, pick an owner; latch Addr/WData/We; GrantOwner=owner; go to ACCESS.
- Arbitration:
  - If only one requester is active, grant it.
  - If both are active, grant the one that is not LastOwner.
  - Override: if LastOwner=LDR and LdrLock=1 and LdrReq=1, grant the loader again, unless StarveCnt==STARVE_LIMIT and CpuReq=1, in which case grant the CPU.
  - StarveCnt increments on each loader grant while CpuReq=1. It clears on any CPU grant or when LdrLock=0.
- ACCESS: drive AddressB = latched address.
  - Write: EnableWriteB=1 and WriteData=latched data for exactly this cycle; assert the owner's Ack this cycle; go to IDLE.
  - Read: load the latency counter with READ_LATENCY-1; go to RD_WAIT.
- RD_WAIT: hold AddressB. When the counter reaches 0, register ReadDataB into the owner's RData, pulse the owner's Ack, and go to IDLE. Otherwise decrement.
- Latency, Req sampled high at edge 0:
  - Write: Ack high in cycle 1.
  - Read: Ack high in cycle 1+READ_LATENCY.
- Throughput: one IDLE bubble between transactions. Back-to-back writes = 1 transaction per 2 cycles.
- Ack, GrantOwner and EnableWriteB are only ever asserted for the current owner.
- Requester drops Req before Ack: protocol violation. The transaction still completes and Ack still pulses.
- Addr/WData changes after grant: ignored (latched values are used).
- AddressB, WriteData: hold last value in IDLE. EnableWriteB: 0 outside ACCESS.

Optional Feature:
MMIO_WRITE_GUARD_EN
- Defined: a loader write with IsMMIO=1 during ACCESS is suppressed (EnableWriteB stays 0). LdrAck and LdrErr pulse together. CPU MMIO writes are unaffected.
- Undefined: all writes pass through; LdrErr tied 0.

Decomposition:
- Package mem_arb_pkg:
  - state enum: IDLE, ACCESS, RD_WAIT
  - owner enum: OWN_NONE=0, OWN_CPU=1, OWN_LDR=2
  - latency-counter width constant
- Data widths come from Constants.vh (`DATA_WIDTH).
- One sub-module, rr_picker: 2-way round-robin with lock and starvation counter. Outputs grant owner and next LastOwner.

Test Plan:
1. CPU write Addr=0x0000_0004, WData=0x1234_5678 -> EnableWriteB high exactly 1 cycle with AddressB=0x4, WriteData=0x12345678; CpuAck pulse in cycle 1.
2. CPU read 0x0000_0004 against a 1-cycle memory model -> CpuAck in cycle 2, CpuRData=0x12345678; repeat with READ_LATENCY=3 -> Ack in cycle 4.
3. CpuReq and LdrReq rise together after reset (LastOwner=CPU) -> GrantOwner sequence 2 then 1; each Ack fires once.
4. LdrLock=1 and both requesting continuously, STARVE_LIMIT=8 -> 8 loader grants, then 1 CPU grant, then loader again.
5. reset driven to 0 mid-RD_WAIT -> all outputs 0 immediately, no Ack; after release, Busy=0 and a fresh request completes normally.
6. With MMIO_WRITE_GUARD_EN: loader write 0xFFFF_FF00 with IsMMIO=1 -> EnableWriteB stays 0, LdrAck=LdrErr=1 for one cycle. Without the macro -> EnableWriteB pulses and LdrErr=0.
